// File: rtl/uart_frame_streamer.sv
// Serialises a wide payload as back-to-back UART bytes (MSB byte first, LSB bit first).
// Define UART_FRAME_STREAMER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_frame_streamer #(
    parameter int DATA_WIDTH         = 2080,
    parameter int UART_TICKS_PER_BIT = 65,
    parameter int STOP_BITS          = 1,
    parameter int GAP_BITS           = 0,
    parameter int AUTO_REPEAT        = 1,
    parameter int DIVIDER_TICKS      = 15
) (
    input  logic                                 clk_in,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 start,
    output logic                                 tx_out,
    output logic                                 busy,
    output logic                                 byte_pulse,
    output logic                                 done_pulse,
    output logic [$clog2(DATA_WIDTH/8+1)-1:0]    byte_index
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
    localparam int TOTAL_BYTES = NUM_BYTES + 1;
`else
    localparam int TOTAL_BYTES = NUM_BYTES;
`endif
    localparam int IDX_W  = $clog2(NUM_BYTES + 1);
    localparam int TICK_W = $clog2(UART_TICKS_PER_BIT);
    localparam int DIV_W  = (DIVIDER_TICKS > 1) ? $clog2(DIVIDER_TICKS) : 1;
    localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UART_TICKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVIDER_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TOTAL_BYTES - 1);

    typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, STOP_BITS_S, GAP} state_t;

    state_t                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [2:0]              bit_q, bit_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    bp_q, bp_d;
    logic                    dp_q, dp_d;
    logic                    auto_trig;
    logic                    trigger;
    logic                    bit_end;
    logic [7:0]              cur_byte;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    // Free-running periodic trigger; keeps counting while a frame is in flight.
    generate
        if (AUTO_REPEAT != 0) begin : g_div
            logic [DIV_W-1:0] div_q, div_d;

            always_comb begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            end

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign auto_trig = (div_q == DIV_LAST);
        end else begin : g_no_div
            assign auto_trig = 1'b0;
        end
    endgenerate

    assign trigger  = start | auto_trig;
    assign bit_end  = (tick_q == TICK_LAST);
    assign cur_byte = shift_q[DATA_WIDTH-1 -: 8];

    always_comb begin
        state_d = state_q;
        tick_d  = bit_end ? '0 : tick_q + TICK_W'(1);
        bit_d   = bit_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        bp_d    = 1'b0;
        dp_d    = 1'b0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (trigger) begin
                    state_d = START_BIT;
                    shift_d = data_in;
                    bit_d   = '0;
                    idx_d   = '0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            START_BIT: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA_BITS;
                    bit_d   = '0;
                end
            end
            DATA_BITS: begin
                tx_d = cur_byte[bit_q];
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BITS_S;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP_BITS_S: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bp_d    = 1'b1;
                        bit_d   = '0;
                        shift_d = shift_q << 8;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
                        // The byte after the last payload byte is the running XOR.
                        csum_d = csum_q ^ cur_byte;
                        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
                            shift_d[DATA_WIDTH-1 -: 8] = csum_q ^ cur_byte;
                        end
`endif
                        if (idx_q == LAST_IDX) begin
                            dp_d    = 1'b1;
                            idx_d   = '0;
                            gap_d   = '0;
                            state_d = (GAP_BITS == 0) ? IDLE : GAP;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = START_BIT;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            bp_q    <= 1'b0;
            dp_q    <= 1'b0;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            bp_q    <= bp_d;
            dp_q    <= dp_d;
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign tx_out     = tx_q;
    assign busy       = (state_q != IDLE);
    assign byte_pulse = bp_q;
    assign done_pulse = dp_q;
    assign byte_index = idx_q;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Directed bench for uart_frame_streamer: basic frame table, stop/gap timing,
// periodic trigger rules, mid-frame reset and data stability.
module tb_uart_frame_streamer;

`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
    localparam int NB_A = 3;
    localparam int NB_C = 2;
`else
    localparam int NB_A = 2;
    localparam int NB_C = 1;
`endif
    localparam int FE_A = 40 * NB_A;
    localparam int FE_B = 44 * NB_A;
    localparam int FL_C = 20 * NB_C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [15:0] data_a = '0, data_b = '0;
    logic [7:0]  data_c = '0;
    logic        tx_a, busy_a, bp_a, dp_a;
    logic        tx_b, busy_b, bp_b, dp_b;
    logic        tx_c, busy_c, bp_c, dp_c;
    logic [1:0]  idx_a, idx_b;
    logic [0:0]  idx_c;

    uart_frame_streamer #(.DATA_WIDTH(16), .UART_TICKS_PER_BIT(4), .STOP_BITS(1),
                          .GAP_BITS(0), .AUTO_REPEAT(0), .DIVIDER_TICKS(15)) u_a (
        .clk_in(clk), .reset(rst_a), .data_in(data_a), .start(start_a), .tx_out(tx_a),
        .busy(busy_a), .byte_pulse(bp_a), .done_pulse(dp_a), .byte_index(idx_a));

    uart_frame_streamer #(.DATA_WIDTH(16), .UART_TICKS_PER_BIT(4), .STOP_BITS(2),
                          .GAP_BITS(3), .AUTO_REPEAT(0), .DIVIDER_TICKS(15)) u_b (
        .clk_in(clk), .reset(rst_b), .data_in(data_b), .start(start_b), .tx_out(tx_b),
        .busy(busy_b), .byte_pulse(bp_b), .done_pulse(dp_b), .byte_index(idx_b));

    uart_frame_streamer #(.DATA_WIDTH(8), .UART_TICKS_PER_BIT(2), .STOP_BITS(1),
                          .GAP_BITS(0), .AUTO_REPEAT(1), .DIVIDER_TICKS(15)) u_c (
        .clk_in(clk), .reset(rst_c), .data_in(data_c), .start(start_c), .tx_out(tx_c),
        .busy(busy_c), .byte_pulse(bp_c), .done_pulse(dp_c), .byte_index(idx_c));

    typedef struct {
        int         off;
        logic       tx;
        logic       busy;
        logic       bp;
        logic       dp;
        logic [1:0] idx;
    } vec_t;

    vec_t tab[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Hand-derived line levels, one per bit period: A5 then 5A (then FF checksum).
`ifdef UART_FRAME_STREAMER_CHECKSUM_EN
    logic lv_a[NB_A*10] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,1,1,0,1,0,1, 0,1,1,1,1,1,1,1,1,1};
`else
    logic lv_a[NB_A*10] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,1,1,0,1,0,1};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ti;
        int nbp;
        int cnt;
        int fs;

        // Table for the basic frame: first and last cycle of every bit period.
        for (int b = 0; b < NB_A * 10; b++) begin
            for (int e = 0; e < 2; e++) begin
                vec_t v;
                logic last;
                v.off  = 4 * b + ((e == 0) ? 1 : 4);
                last   = (e == 1) && (b % 10 == 9);
                v.tx   = lv_a[b];
                v.bp   = last;
                v.dp   = last && (v.off == FE_A);
                v.busy = !v.dp;
                v.idx  = last ? (v.dp ? 2'd0 : 2'(b / 10 + 1)) : 2'(b / 10);
                tab.push_back(v);
            end
        end

        // ---------------- Instance A: basic frame ----------------
        step();
        step();
        chk("A reset tx", 32'(tx_a), 32'd1);
        chk("A reset busy", 32'(busy_a), 32'd0);
        chk("A reset byte_pulse", 32'(bp_a), 32'd0);
        chk("A reset done_pulse", 32'(dp_a), 32'd0);
        chk("A reset byte_index", 32'(idx_a), 32'd0);
        rst_a   = 1'b0;
        data_a  = 16'hA55A;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        $display("A: frame 16'hA55A accepted at %0t", $time);
        chk("A accept busy", 32'(busy_a), 32'd1);
        chk("A accept tx", 32'(tx_a), 32'd1);
        ti  = 0;
        nbp = 0;
        for (int off = 1; off <= FE_A; off++) begin
            step();
            if (off == 1) data_a = 16'hFFFF;
            if (bp_a) nbp++;
            while (ti < tab.size() && tab[ti].off == off) begin
                chk($sformatf("A tx off%0d", off), 32'(tx_a), 32'(tab[ti].tx));
                chk($sformatf("A busy off%0d", off), 32'(busy_a), 32'(tab[ti].busy));
                chk($sformatf("A byte_pulse off%0d", off), 32'(bp_a), 32'(tab[ti].bp));
                chk($sformatf("A done_pulse off%0d", off), 32'(dp_a), 32'(tab[ti].dp));
                chk($sformatf("A byte_index off%0d", off), 32'(idx_a), 32'(tab[ti].idx));
                ti++;
            end
            if (off == FE_A - 1) start_a = 1'b1;
        end
        chk("A byte_pulse count", 32'(nbp), 32'(NB_A));
        // Start held high: dropped on the busy-fall edge, accepted one edge later.
        step();
        start_a = 1'b0;
        chk("A retrigger busy", 32'(busy_a), 32'd1);
        chk("A retrigger tx still idle", 32'(tx_a), 32'd1);
        step();
        chk("A retrigger start bit", 32'(tx_a), 32'd0);
        $display("A: back-to-back frame accepted at %0t", $time);
        for (int i = 0; i < 20; i++) step();
        chk("A busy before reset", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("A abort tx", 32'(tx_a), 32'd1);
        chk("A abort busy", 32'(busy_a), 32'd0);
        chk("A abort byte_index", 32'(idx_a), 32'd0);
        chk("A abort byte_pulse", 32'(bp_a), 32'd0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bp_a || dp_a || !tx_a || busy_a) cnt++;
        end
        chk("A activity after abort", 32'(cnt), 32'd0);
        $display("A: mid-frame reset sequence done at %0t", $time);

        // ---------------- Instance B: 2 stop bits, 3-bit gap ----------------
        step();
        rst_b   = 1'b0;
        data_b  = 16'hA55A;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        $display("B: frame 16'hA55A accepted at %0t", $time);
        cnt = 0;
        for (int off = 1; off <= FE_B + 14; off++) begin
            step();
            start_b = 1'b0;
            if (off == 44) begin
                chk("B byte_pulse off44", 32'(bp_b), 32'd1);
                chk("B stop2 tx off44", 32'(tx_b), 32'd1);
            end
            if (off == 45) begin
                chk("B byte1 start bit", 32'(tx_b), 32'd0);
                chk("B byte_pulse off45", 32'(bp_b), 32'd0);
            end
            if (off == FE_B) begin
                chk("B done_pulse", 32'(dp_b), 32'd1);
                chk("B busy at done", 32'(busy_b), 32'd1);
            end
            if (off > FE_B && off <= FE_B + 12 && !tx_b) cnt++;
            if (off == FE_B + 11) chk("B busy end of gap", 32'(busy_b), 32'd1);
            if (off == FE_B + 12) begin
                chk("B busy after gap", 32'(busy_b), 32'd0);
                chk("B gap tx low count", 32'(cnt), 32'd0);
            end
            if (off == FE_B + 13) begin
                chk("B post-gap accept busy", 32'(busy_b), 32'd1);
                chk("B post-gap tx idle", 32'(tx_b), 32'd1);
            end
            if (off == FE_B + 14) chk("B post-gap start bit", 32'(tx_b), 32'd0);
            if (off == FE_B + 4 || off == FE_B + 12) start_b = 1'b1;
        end
        $display("B: gap and retrigger sequence done at %0t", $time);

        // ---------------- Instance C: periodic trigger ----------------
        data_c = 8'h3C;
        step();
        rst_c = 1'b0;
        chk("C reset busy", 32'(busy_c), 32'd0);
        chk("C reset tx", 32'(tx_c), 32'd1);
        fs = -1000;
        for (int n = 1; n <= 110; n++) begin
            logic trig;
            logic txe;
            int   p;
            step();
            start_c = 1'b0;
            trig = ((n - 1) % 15 == 14) || (n == 25) || (n == 38);
            if (trig && (n > fs + FL_C)) begin
                fs = n;
                $display("C: frame expected to start at edge %0d", n);
            end
            if (n >= fs + 1 && n <= fs + FL_C) begin
                p = ((n - fs - 1) / 2) % 10;
                txe = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : data_c[p-1];
            end else begin
                txe = 1'b1;
            end
            chk($sformatf("C tx n%0d", n), 32'(tx_c), 32'(txe));
            chk($sformatf("C busy n%0d", n), 32'(busy_c), 32'((n >= fs) && (n < fs + FL_C)));
            chk($sformatf("C done n%0d", n), 32'(dp_c), 32'(n == fs + FL_C));
            if (n == 24 || n == 37) start_c = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
